// File: rtl/music_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : music_mixer
//  Purpose  : DC-removes, volume-scales and sums the PSG music and sfx sources
//             into signed 16-bit PCM, with a CPU-driven linear music fade.
//  Revision : 1.0  initial release
// ============================================================================
module music_mixer #(
  parameter int SAMPLE_DIV    = 500,
  parameter int FADE_PRESCALE = 24000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic [7:0]  data_in,
  input  logic        write,
  output logic [7:0]  data_out,
  input  logic [9:0]  music_in,
  input  logic [9:0]  sfx_in,
  output logic [15:0] audio_out,
  output logic        sample_strobe
);

  localparam int SW = (SAMPLE_DIV    > 1) ? $clog2(SAMPLE_DIV)    : 1;
  localparam int FW = (FADE_PRESCALE > 1) ? $clog2(FADE_PRESCALE) : 1;

  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_DIV - 1);
  localparam logic [FW-1:0] FADE_LAST   = FW'(FADE_PRESCALE - 1);

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_TARGET  = 2'd1;
  localparam logic [1:0] ADDR_RATE    = 2'd2;
  localparam logic [1:0] ADDR_SFX_VOL = 2'd3;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_FADING = 1'b1
  } fade_state_t;

  // --------------------------------------------------------------------------
  // Free-running tick generators
  // --------------------------------------------------------------------------
  logic [SW-1:0] sdiv_q, sdiv_d;
  logic [FW-1:0] fdiv_q, fdiv_d;
  logic          sample_tick;
  logic          fade_tick;

  assign sample_tick = (sdiv_q == SAMPLE_LAST);
  assign fade_tick   = (fdiv_q == FADE_LAST);

  always_comb begin
    sdiv_d = sample_tick ? '0 : sdiv_q + SW'(1);
    fdiv_d = fade_tick   ? '0 : fdiv_q + FW'(1);
  end

  // --------------------------------------------------------------------------
  // CPU register file
  // --------------------------------------------------------------------------
  logic [7:0] target_reg_q, target_reg_d;
  logic [7:0] rate_reg_q,   rate_reg_d;
  logic [7:0] sfx_vol_q,    sfx_vol_d;
  logic       mute_q,       mute_d;
  logic       fade_go;

  assign fade_go = write && (addr == ADDR_CTRL) && data_in[1];

  always_comb begin
    target_reg_d = target_reg_q;
    rate_reg_d   = rate_reg_q;
    sfx_vol_d    = sfx_vol_q;
    mute_d       = mute_q;
    if (write) begin
      case (addr)
        ADDR_CTRL:    mute_d       = data_in[0];
        ADDR_TARGET:  target_reg_d = data_in;
        ADDR_RATE:    rate_reg_d   = data_in;
        ADDR_SFX_VOL: sfx_vol_d    = data_in;
        default:      mute_d       = mute_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Fade FSM
  // --------------------------------------------------------------------------
  fade_state_t state_q, state_d;
  logic [7:0]  music_vol_q,      music_vol_d;
  logic [7:0]  target_latched_q, target_latched_d;
  logic [7:0]  rate_latched_q,   rate_latched_d;
  logic [7:0]  step_q,           step_d;
  logic [7:0]  step_inc;
  logic [7:0]  vol_step;

  assign step_inc = step_q + 8'd1;
  assign vol_step = (music_vol_q < target_latched_q) ? music_vol_q + 8'd1
                                                     : music_vol_q - 8'd1;

  always_comb begin
    state_d          = state_q;
    music_vol_d      = music_vol_q;
    target_latched_d = target_latched_q;
    rate_latched_d   = rate_latched_q;
    step_d           = step_q;
    if (fade_go) begin
      // A coincident fade tick is deliberately dropped: the fade restarts here.
      target_latched_d = target_reg_q;
      rate_latched_d   = rate_reg_q;
      step_d           = 8'd0;
      if ((rate_reg_q == 8'd0) || (music_vol_q == target_reg_q)) begin
        music_vol_d = target_reg_q;
        state_d     = ST_IDLE;
      end else begin
        state_d     = ST_FADING;
      end
    end else if ((state_q == ST_FADING) && fade_tick) begin
      if (step_inc == rate_latched_q) begin
        step_d      = 8'd0;
        music_vol_d = vol_step;
        if (vol_step == target_latched_q) begin
          state_d = ST_IDLE;
        end
      end else begin
        step_d = step_inc;
      end
    end
  end

  assign data_out = {5'b00000, mute_q, (music_vol_q == target_latched_q),
                     (state_q == ST_FADING)};

  // --------------------------------------------------------------------------
  // Three-stage mixing pipeline
  // --------------------------------------------------------------------------
  logic               v1_q, v1_d;
  logic               v2_q, v2_d;
  logic signed [10:0] m_q,  m_d;
  logic signed [10:0] s_q,  s_d;
  logic signed [18:0] pm_q, pm_d;
  logic signed [18:0] ps_q, ps_d;
  logic signed [18:0] m_ext, s_ext, mv_ext, sv_ext;
  logic signed [18:0] sum;
  logic [15:0]        audio_q, audio_d;
  logic               strobe_q, strobe_d;

  assign m_ext  = 19'(m_q);
  assign s_ext  = 19'(s_q);
  assign mv_ext = 19'($signed({1'b0, music_vol_q}));
  assign sv_ext = 19'($signed({1'b0, sfx_vol_q}));
  // 19 bits hold the full +/-2*511*255 range, so the sum cannot wrap.
  assign sum    = pm_q + ps_q;

  always_comb begin
    v1_d     = sample_tick;
    m_d      = m_q;
    s_d      = s_q;
    if (sample_tick) begin
      m_d = $signed({1'b0, music_in}) - 11'sd512;
      s_d = $signed({1'b0, sfx_in})   - 11'sd512;
    end

    v2_d     = v1_q;
    pm_d     = pm_q;
    ps_d     = ps_q;
    if (v1_q) begin
      pm_d = mute_q ? 19'sd0 : m_ext * mv_ext;
      ps_d = s_ext * sv_ext;
    end

    strobe_d = v2_q;
    audio_d  = audio_q;
    if (v2_q) begin
      audio_d = 16'(sum >>> 3);
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sdiv_q           <= '0;
      fdiv_q           <= '0;
      target_reg_q     <= 8'hFF;
      rate_reg_q       <= 8'h00;
      sfx_vol_q        <= 8'hFF;
      mute_q           <= 1'b0;
      state_q          <= ST_IDLE;
      music_vol_q      <= 8'hFF;
      target_latched_q <= 8'hFF;
      rate_latched_q   <= 8'h00;
      step_q           <= 8'h00;
      v1_q             <= 1'b0;
      v2_q             <= 1'b0;
      m_q              <= '0;
      s_q              <= '0;
      pm_q             <= '0;
      ps_q             <= '0;
      audio_q          <= '0;
      strobe_q         <= 1'b0;
    end else begin
      sdiv_q           <= sdiv_d;
      fdiv_q           <= fdiv_d;
      target_reg_q     <= target_reg_d;
      rate_reg_q       <= rate_reg_d;
      sfx_vol_q        <= sfx_vol_d;
      mute_q           <= mute_d;
      state_q          <= state_d;
      music_vol_q      <= music_vol_d;
      target_latched_q <= target_latched_d;
      rate_latched_q   <= rate_latched_d;
      step_q           <= step_d;
      v1_q             <= v1_d;
      v2_q             <= v2_d;
      m_q              <= m_d;
      s_q              <= s_d;
      pm_q             <= pm_d;
      ps_q             <= ps_d;
      audio_q          <= audio_d;
      strobe_q         <= strobe_d;
    end
  end

  assign audio_out     = audio_q;
  assign sample_strobe = strobe_q;

endmodule
`default_nettype wire

// File: tb/tb_music_mixer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_music_mixer
//  Purpose  : Scoreboard bench for music_mixer with directed mixing/fade vectors.
//  Revision : 1.0  initial release
// ============================================================================
module tb_music_mixer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic [7:0]  data_in;
  logic        write;
  logic [7:0]  data_out;
  logic [9:0]  music_in;
  logic [9:0]  sfx_in;
  logic [15:0] audio_out;
  logic        sample_strobe;

  music_mixer #(.SAMPLE_DIV(4), .FADE_PRESCALE(10)) dut (
    .clk           (clk),
    .reset         (reset),
    .addr          (addr),
    .data_in       (data_in),
    .write         (write),
    .data_out      (data_out),
    .music_in      (music_in),
    .sfx_in        (sfx_in),
    .audio_out     (audio_out),
    .sample_strobe (sample_strobe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic signed [15:0] exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Cycle bookkeeping for strobe spacing and first-strobe latency after reset
  int cyc = 0;
  int rst_cyc = 0;
  int last_strobe = 0;
  bit after_rst = 1'b1;

  always @(posedge clk) begin
    cyc++;
    if (reset) rst_cyc = cyc;
  end

  // Monitor: pops the scoreboard whenever the DUT presents a sample
  always @(negedge clk) begin
    if (reset) begin
      after_rst = 1'b1;
    end else if (sample_strobe) begin
      if (after_rst) begin
        check("first_strobe_latency", cyc - rst_cyc, 6);
        after_rst = 1'b0;
      end else begin
        check("strobe_period", cyc - last_strobe, 4);
      end
      last_strobe = cyc;
      if (exp_q.size() != 0) begin
        check("audio_out", int'($signed(audio_out)), int'(exp_q.pop_front()));
      end
    end
  end

  task automatic wr(input logic [1:0] a, input logic [7:0] d);
    addr    = a;
    data_in = d;
    write   = 1'b1;
    @(negedge clk);
    write   = 1'b0;
  endtask

  task automatic expect_audio(input logic signed [15:0] v);
    int n;
    repeat (8) @(negedge clk);
    exp_q.push_back(v);
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL audio_timeout: no strobe within %0d cycles, expected %0d", n, v);
      exp_q.delete();
    end
  endtask

  initial begin
    reset    = 1'b1;
    write    = 1'b0;
    addr     = 2'd0;
    data_in  = 8'd0;
    music_in = 10'd512;
    sfx_in   = 10'd512;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_audio",    int'(audio_out),     0);
    check("rst_strobe",   int'(sample_strobe), 0);
    check("rst_data_out", int'(data_out),      8'h02);
    reset = 1'b0;

    // Full-scale positive music, silent sfx
    music_in = 10'd1023;
    expect_audio(16'sd16288);
    // Full-scale negative on both sources
    music_in = 10'd0;
    sfx_in   = 10'd0;
    expect_audio(-16'sd32640);
    music_in = 10'd512;
    sfx_in   = 10'd512;
    expect_audio(16'sd0);
    // -255 >>> 3 floors to -32
    music_in = 10'd511;
    expect_audio(-16'sd32);
    // sfx volume scaling: 511*64 >>> 3
    music_in = 10'd512;
    sfx_in   = 10'd1023;
    wr(2'd3, 8'h40);
    expect_audio(16'sd4088);
    wr(2'd3, 8'hFF);

    // Slow fade FF -> 0 at two ticks per step
    sfx_in   = 10'd512;
    music_in = 10'd1023;
    wr(2'd2, 8'd2);
    wr(2'd1, 8'd0);
    wr(2'd0, 8'h02);
    check("fade_started", int'(data_out), 8'h01);
    repeat (5089) @(negedge clk);
    check("fade_last_step_pending", int'(data_out), 8'h01);
    repeat (11) @(negedge clk);
    check("fade_done", int'(data_out), 8'h02);
    expect_audio(16'sd0);

    // RATE=0 jumps straight to target
    wr(2'd2, 8'd0);
    wr(2'd1, 8'h80);
    wr(2'd0, 8'h02);
    check("jump_no_fading", int'(data_out), 8'h02);
    expect_audio(16'sd8176);

    // Start downwards, then reverse mid-fade toward FF
    wr(2'd2, 8'd1);
    wr(2'd1, 8'h00);
    wr(2'd0, 8'h02);
    check("down_fading", int'(data_out), 8'h01);
    repeat (50) @(negedge clk);
    wr(2'd1, 8'hFF);
    check("target_write_no_effect", int'(data_out), 8'h01);
    wr(2'd0, 8'h02);
    check("reverse_fading", int'(data_out), 8'h01);
    repeat (1400) @(negedge clk);
    check("reverse_done", int'(data_out), 8'h02);
    expect_audio(16'sd16288);

    // Mute: only sfx reaches the output
    wr(2'd0, 8'h01);
    check("mute_status", int'(data_out), 8'h06);
    music_in = 10'd1023;
    sfx_in   = 10'd1023;
    expect_audio(16'sd16288);

    // Reset in the middle of a fade
    wr(2'd2, 8'd2);
    wr(2'd1, 8'd0);
    wr(2'd0, 8'h03);
    check("mute_fading_status", int'(data_out), 8'h05);
    repeat (100) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midfade_rst_data_out", int'(data_out),      8'h02);
    check("midfade_rst_audio",    int'(audio_out),     0);
    check("midfade_rst_strobe",   int'(sample_strobe), 0);
    reset = 1'b0;
    expect_audio(16'sd32576);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
